// File: rtl/pipe_pkg_amisha.sv
// Shared definitions for the enabled pipeline register family.
//   occ_w()      : width of an occupancy counter able to hold 0..depth
//   stage_op_e   : per-cycle pipeline operation decoded from flush/enable
package pipe_pkg_amisha;

    // Per-cycle operation applied to every stage; reset is handled separately
    // because it also reloads stage data.
    typedef enum logic [1:0] {
        StageHold    = 2'b00,
        StageAdvance = 2'b01,
        StageFlush   = 2'b10
    } stage_op_e;

    // Counter width for values 0..depth inclusive.
    function automatic int unsigned occ_w(input int unsigned depth);
        return (depth + 1 <= 2) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage_amisha.sv
// One pipeline stage: WIDTH-bit data register plus valid bit.
// Ports:
//   clk_amisha       : clock, posedge
//   reset_amisha     : synchronous active-low reset (data <= RESET_VAL, valid <= 0)
//   load_amisha      : capture d/v inputs
//   clr_valid_amisha : clear valid, keep data (wins over load)
//   d_amisha, v_in_amisha   : data and valid from the previous stage
//   q_amisha, v_out_amisha  : registered data and valid
module pipe_stage_amisha #(
    parameter int unsigned WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_amisha,
    input  logic             reset_amisha,
    input  logic             load_amisha,
    input  logic             clr_valid_amisha,
    input  logic [WIDTH-1:0] d_amisha,
    input  logic             v_in_amisha,
    output logic [WIDTH-1:0] q_amisha,
    output logic             v_out_amisha
);

    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    always_ff @(posedge clk_amisha) begin
        if (!reset_amisha) begin
            data_q  <= RESET_VAL;
            valid_q <= 1'b0;
        end else if (clr_valid_amisha) begin
            valid_q <= 1'b0;
        end else if (load_amisha) begin
            data_q  <= d_amisha;
            valid_q <= v_in_amisha;
        end
    end

    assign q_amisha     = data_q;
    assign v_out_amisha = valid_q;

endmodule

// File: rtl/pipe_reg_en_amisha.sv
// DEPTH-stage enabled pipeline register with per-stage valid bits, flush,
// bubble handling and a registered occupancy count.
// Ports:
//   clk_amisha       : clock, posedge
//   reset_amisha     : synchronous active-low reset, highest priority
//   en_amisha        : advance one stage (0 = hold)
//   flush_amisha     : invalidate all stages, data retained, input dropped
//   in_valid_amisha  : d_amisha carries valid data
//   d_amisha         : input data
//   q_amisha         : data of last stage
//   out_valid_amisha : valid of last stage
//   occ_amisha       : number of valid stages, 0..DEPTH
module pipe_reg_en_amisha
    import pipe_pkg_amisha::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      DEPTH       = 3,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0,
    parameter bit               BUBBLE_ZERO = 1'b0,
    localparam int unsigned     OCC_W       = occ_w(DEPTH)
) (
    input  logic             clk_amisha,
    input  logic             reset_amisha,
    input  logic             en_amisha,
    input  logic             flush_amisha,
    input  logic             in_valid_amisha,
    input  logic [WIDTH-1:0] d_amisha,
    output logic [WIDTH-1:0] q_amisha,
    output logic             out_valid_amisha,
    output logic [OCC_W-1:0] occ_amisha
);

    stage_op_e        op;
    logic [WIDTH-1:0] stage0_d;
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [DEPTH-1:0] stage_v;
    logic [OCC_W-1:0] occ_q, occ_d;

    always_comb begin
        if (flush_amisha) begin
            op = StageFlush;
        end else if (en_amisha) begin
            op = StageAdvance;
        end else begin
            op = StageHold;
        end
    end

    // Bubble mux selects a constant so X on d during a bubble never propagates.
    assign stage0_d = (BUBBLE_ZERO && !in_valid_amisha) ? RESET_VAL : d_amisha;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] d_in;
        logic             v_in;

        if (k == 0) begin : g_first
            assign d_in = stage0_d;
            assign v_in = in_valid_amisha;
        end else begin : g_rest
            assign d_in = stage_q[k-1];
            assign v_in = stage_v[k-1];
        end

        pipe_stage_amisha #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk_amisha       (clk_amisha),
            .reset_amisha     (reset_amisha),
            .load_amisha      (op == StageAdvance),
            .clr_valid_amisha (op == StageFlush),
            .d_amisha         (d_in),
            .v_in_amisha      (v_in),
            .q_amisha         (stage_q[k]),
            .v_out_amisha     (stage_v[k])
        );
    end

    always_comb begin
        occ_d = occ_q;
        unique case (op)
            StageFlush:   occ_d = '0;
            StageAdvance: occ_d = occ_q + OCC_W'(in_valid_amisha) - OCC_W'(stage_v[DEPTH-1]);
            StageHold:    occ_d = occ_q;
            default:      occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk_amisha) begin
        if (!reset_amisha) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign q_amisha         = stage_q[DEPTH-1];
    assign out_valid_amisha = stage_v[DEPTH-1];
    assign occ_amisha       = occ_q;

    occ_matches_valid_a: assert property (
        @(posedge clk_amisha) disable iff (!reset_amisha)
        occ_q == OCC_W'($countones(stage_v))
    );

endmodule

// File: tb/tb_pipe_reg_en_amisha.sv
module tb_pipe_reg_en_amisha;

    logic       clk_amisha = 1'b0;
    logic       reset_amisha;
    logic       en_amisha;
    logic       flush_amisha;
    logic       in_valid_amisha;
    logic [7:0] d_amisha;

    logic [7:0] q_a, q_b, q_c;
    logic       v_a, v_b, v_c;
    logic [1:0] occ_a, occ_b, occ_c;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk_amisha = ~clk_amisha;

    // Default configuration.
    pipe_reg_en_amisha #(
        .WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00), .BUBBLE_ZERO(1'b0)
    ) dut_a (
        .clk_amisha       (clk_amisha),
        .reset_amisha     (reset_amisha),
        .en_amisha        (en_amisha),
        .flush_amisha     (flush_amisha),
        .in_valid_amisha  (in_valid_amisha),
        .d_amisha         (d_amisha),
        .q_amisha         (q_a),
        .out_valid_amisha (v_a),
        .occ_amisha       (occ_a)
    );

    // Bubbles load RESET_VAL.
    pipe_reg_en_amisha #(
        .WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00), .BUBBLE_ZERO(1'b1)
    ) dut_b (
        .clk_amisha       (clk_amisha),
        .reset_amisha     (reset_amisha),
        .en_amisha        (en_amisha),
        .flush_amisha     (flush_amisha),
        .in_valid_amisha  (in_valid_amisha),
        .d_amisha         (d_amisha),
        .q_amisha         (q_b),
        .out_valid_amisha (v_b),
        .occ_amisha       (occ_b)
    );

    // Non-zero reset value.
    pipe_reg_en_amisha #(
        .WIDTH(8), .DEPTH(3), .RESET_VAL(8'hFF), .BUBBLE_ZERO(1'b0)
    ) dut_c (
        .clk_amisha       (clk_amisha),
        .reset_amisha     (reset_amisha),
        .en_amisha        (en_amisha),
        .flush_amisha     (flush_amisha),
        .in_valid_amisha  (in_valid_amisha),
        .d_amisha         (d_amisha),
        .q_amisha         (q_c),
        .out_valid_amisha (v_c),
        .occ_amisha       (occ_c)
    );

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       flush;
        logic       iv;
        logic [7:0] d;
        logic [7:0] q_a;
        logic [7:0] q_b;
        logic       v;
        logic [1:0] occ;
    } vec_t;

    localparam int NVEC = 18;
    vec_t tbl [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs just after a posedge, then wait for the next edge and settle.
    task automatic step(input logic rst_n, input logic en, input logic flush,
                        input logic iv, input logic [7:0] d);
        reset_amisha    = rst_n;
        en_amisha       = en;
        flush_amisha    = flush;
        in_valid_amisha = iv;
        d_amisha        = d;
        @(posedge clk_amisha);
        #1;
    endtask

    initial begin
        reset_amisha    = 1'b0;
        en_amisha       = 1'b0;
        flush_amisha    = 1'b0;
        in_valid_amisha = 1'b0;
        d_amisha        = 8'h00;

        //             rst  en   fl   iv   d      q_a    q_b    v    occ
        // Reset with valid AA pushed: nothing emerges.
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'hAA, 8'h00, 8'h00, 1'b0, 2'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'hAA, 8'h00, 8'h00, 1'b0, 2'd0};
        // Stream 11,22,33.
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 8'h00, 8'h00, 1'b0, 2'd1};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h22, 8'h00, 8'h00, 1'b0, 2'd2};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 8'h11, 8'h11, 1'b1, 2'd3};
        // Stall two cycles with EE offered, then resume.
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hEE, 8'h11, 8'h11, 1'b1, 2'd3};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hEE, 8'h11, 8'h11, 1'b1, 2'd3};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h44, 8'h22, 8'h22, 1'b1, 2'd3};
        // Bubbles carrying 55 drain the pipe.
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h55, 8'h33, 8'h33, 1'b1, 2'd2};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h55, 8'h44, 8'h44, 1'b1, 2'd1};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h55, 8'h55, 8'h00, 1'b0, 2'd0};
        // Refill, behind the bubbles.
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h61, 8'h55, 8'h00, 1'b0, 2'd1};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h62, 8'h55, 8'h00, 1'b0, 2'd2};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h63, 8'h61, 8'h61, 1'b1, 2'd3};
        // Flush with valid 77 offered: dropped, data retained but invalid.
        tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h77, 8'h61, 8'h61, 1'b0, 2'd0};
        tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h62, 8'h62, 1'b0, 2'd0};
        tbl[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h63, 8'h63, 1'b0, 2'd0};
        tbl[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 2'd0};

        @(negedge clk_amisha);
        for (int i = 0; i < NVEC; i++) begin
            step(tbl[i].rst_n, tbl[i].en, tbl[i].flush, tbl[i].iv, tbl[i].d);
            check($sformatf("row%0d q_a", i),   32'(q_a),   32'(tbl[i].q_a));
            check($sformatf("row%0d v_a", i),   32'(v_a),   32'(tbl[i].v));
            check($sformatf("row%0d occ_a", i), 32'(occ_a), 32'(tbl[i].occ));
            check($sformatf("row%0d q_b", i),   32'(q_b),   32'(tbl[i].q_b));
            check($sformatf("row%0d v_b", i),   32'(v_b),   32'(tbl[i].v));
            check($sformatf("row%0d occ_b", i), 32'(occ_b), 32'(tbl[i].occ));
        end

        // Flush while stalled still invalidates.
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h71);
        check("stall_flush occ before", 32'(occ_a), 32'd1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h72);
        check("stall_flush occ", 32'(occ_a), 32'd0);
        check("stall_flush v", 32'(v_a), 32'd0);

        // Mid-stream reset on the RESET_VAL=FF instance, with flush on the same edge.
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h81);
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h82);
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h83);
        check("c full q", 32'(q_c), 32'h81);
        check("c full v", 32'(v_c), 32'd1);
        check("c full occ", 32'(occ_c), 32'd3);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h84);
        check("c reset q", 32'(q_c), 32'hFF);
        check("c reset v", 32'(v_c), 32'd0);
        check("c reset occ", 32'(occ_c), 32'd0);
        check("a reset q", 32'(q_a), 32'h00);
        // Restart streaming: one valid word followed by bubbles.
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h91);
        check("c restart occ1", 32'(occ_c), 32'd1);
        check("c restart q1", 32'(q_c), 32'hFF);
        check("c restart v1", 32'(v_c), 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        check("c restart q2", 32'(q_c), 32'hFF);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        check("c restart q3", 32'(q_c), 32'h91);
        check("c restart v3", 32'(v_c), 32'd1);
        check("c restart occ3", 32'(occ_c), 32'd1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        check("c drain v", 32'(v_c), 32'd0);
        check("c drain occ", 32'(occ_c), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
